dmem_byte: RTL and testbench
============================

DMEM_BYTE -- requirements
Module: dmem_byte

Interface
REQ-001 Parameter: DEPTH, default 8192, number of 32-bit words; power of two, >= 4.
REQ-002 Parameter: ADDR_W, default $clog2(DEPTH)+2, byte-address width (derived; not overridden).
REQ-003 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: req_valid  in  1  request present.
REQ-006 Port: req_we  in  1  1 = store, 0 = load.
REQ-007 Port: req_addr  in  ADDR_W  byte address.
REQ-008 Port: req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 Port: req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 Port: req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port: req_ready  out  1  request accepted this cycle when req_valid && req_ready.
REQ-012 Port: rsp_valid  out  1  one-cycle pulse per accepted request.
REQ-013 Port: rsp_rdata  out  32  formatted load data; 0 for stores and faults.
REQ-014 Port: rsp_misalign  out  1  accepted request was misaligned; qualified by rsp_valid.
REQ-015 Port: busy  out  1  clear sweep in progress.

Function
REQ-016 req_ready shall equal !busy; requests presented while busy are neither accepted nor answered.
REQ-017 Every accepted request shall produce exactly one rsp_valid pulse, exactly 1 cycle later; back-to-back requests shall be accepted every cycle.
REQ-018 Word index shall be req_addr[ADDR_W-1:2]; byte lane shall be req_addr[1:0].
REQ-019 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0; the array is not written, rsp_misalign=1, rsp_rdata=0.
REQ-020 An aligned store shall write only the addressed lanes (byte: 1 lane, half: lanes {addr[1],0..1}, word: all 4), with data replicated into the lane position; other lanes are unchanged.
REQ-021 An aligned load shall return the addressed byte/half shifted to bit 0, extended per req_unsigned; a word load returns the word unchanged.
REQ-022 A load accepted in the cycle after a store to the same word shall return the post-store contents.
REQ-023 With no accepted request, rsp_valid, rsp_misalign and rsp_rdata shall be 0 in the following cycle.
REQ-024 FSM states: CLEAR (busy=1, one word per cycle is written to 0, in ascending index order) and IDLE (busy=0); CLEAR -> IDLE after index DEPTH-1 is written.

Reset
REQ-025 While rst=1: the FSM shall enter CLEAR with the sweep index at 0; rsp_valid=0, rsp_rdata=0, rsp_misalign=0 in the next cycle.
REQ-026 rst asserted mid-sweep shall restart the sweep at index 0; rst asserted mid-request shall discard that response.
REQ-027 busy shall be 1 from the cycle after rst is sampled until DEPTH cycles after rst deasserts; req_ready shall be 1 in the following cycle.

Configuration
REQ-028 Macro DMEM_BYTE_CLEAR_EN: when defined, the CLEAR sweep of REQ-024..027 is compiled in.
REQ-029 Without DMEM_BYTE_CLEAR_EN: no sweep logic; reset goes directly to IDLE; busy is constant 0; array contents after reset are undefined.

Structure
REQ-030 Package dmem_pkg shall hold the size encoding enum (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-031 Sub-module dmem_align (combinational) shall produce the byte-enable mask, the lane-positioned write data, the extracted/extended load data, and the misalign flag.

Verification
REQ-032 Reset, then count cycles until req_ready=1 -> exactly DEPTH (macro on) or 1 (macro off); a word load at 0x10 returns 0x00000000 (macro on).
REQ-033 Store word 0x11223344 @0x20, then load bytes 0x20..0x23 signed -> 0x00000044, 0x00000033, 0x00000022, 0x00000011 on consecutive cycles.
REQ-034 Store byte 0x80 @0x41 over word 0 -> word @0x40 reads 0x00008000; signed byte load @0x41 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Half load @0x43 and word store @0x46 -> rsp_misalign=1, rdata=0; word @0x44 is unchanged.
REQ-036 Store half 0xBEEF @0x52, then load word @0x50 in the next cycle -> 0xBEEF0000 (same-word forwarding per REQ-022).
REQ-037 Assert rst at sweep index 100 -> busy stays 1; sweep restarts at 0; DEPTH further cycles pass before req_ready=1.

Source files
------------

// File: rtl/dmem_byte_pkg.sv
// Shared encodings for the byte-addressable data memory: access size and clear-sweep FSM state.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_align.sv
// Lane steering for byte/half/word accesses: byte enables, lane-replicated store data,
// extracted and extended load data, misalign flag. Purely combinational, no backpressure.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdat,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be       = 4'b0000;
    wdat     = 32'h0;
    rdata    = 32'h0;
    misalign = 1'b0;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << lane;
        wdat  = {4{wdata[7:0]}};
        rdata = {{24{~is_unsigned & rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdat     = {2{wdata[15:0]}};
        rdata    = {{16{~is_unsigned & rhalf[15]}}, rhalf};
      end
      // Size code 11 shares the word path.
      default: begin
        misalign = |lane;
        be       = 4'b1111;
        wdat     = wdata;
        rdata    = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_byte.sv
// Byte-addressable data memory: response exactly 1 cycle after accept; req_ready drops while
// the post-reset zeroing sweep runs (compiled in only with DMEM_BYTE_CLEAR_EN).
module dmem_byte
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic              busy
);

  localparam int IW = ADDR_W - 2;

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] widx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic [31:0]   ld_data;
  logic          mis;
  logic          acc;
  logic          clr_we;
  logic [IW-1:0] clr_idx;

  assign widx      = req_addr[ADDR_W-1:2];
  assign rword     = mem[widx];
  assign req_ready = ~busy;
  assign acc       = req_valid & req_ready & ~rst;

  dmem_align u_align (
    .lane        (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rword       (rword),
    .be          (be),
    .wdat        (wdat),
    .rdata       (ld_data),
    .misalign    (mis)
  );

`ifdef DMEM_BYTE_CLEAR_EN
  state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + IW'(1);
      if (clr_idx == IW'(DEPTH - 1)) state <= ST_IDLE;
    end
  end

  assign busy   = (state == ST_CLEAR);
  assign clr_we = busy & ~rst;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  // Writes land at the accepting edge, so the combinational read of the next accepted
  // request already sees the post-store word without an explicit bypass.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= 32'h0;
    end else if (acc && req_we && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_misalign <= 1'b0;
      rsp_rdata    <= 32'h0;
    end else begin
      rsp_valid    <= acc;
      rsp_misalign <= acc & mis;
      rsp_rdata    <= (acc && !req_we && !mis) ? ld_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_byte.sv
// Self-checking bench for dmem_byte: directed scenarios plus random traffic against a byte-array model.
module tb_dmem_byte;

  localparam int DEPTH = 8192;
  localparam int AW    = $clog2(DEPTH) + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_misalign;
  logic          busy;

  int          ntests = 0;
  int          nfail  = 0;
  logic [7:0]  mb [256];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  dmem_byte #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_misalign (rsp_misalign),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // One request, driven now and checked #1 after the accepting edge against the byte model.
  task automatic do_req(input logic we, input int addr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] wd, input string tag);
    int          n;
    logic        exp_mis;
    logic [31:0] exp_rd;
    n       = nbytes(sz);
    exp_mis = (addr % n) != 0;
    exp_rd  = 32'h0;
    if (!exp_mis) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[addr + i] = 8'(wd >> (8 * i));
      end else begin
        for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(mb[addr + i]) << (8 * i));
        if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'h1 << (8 * n)) - 32'h1);
      end
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = AW'(addr);
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, ".mis"}, 32'(rsp_misalign), 32'(exp_mis));
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    last_rd = rsp_rdata;
  endtask

  task automatic idle_chk(input string tag);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, ".mis"}, 32'(rsp_misalign), 32'h0);
    chk({tag, ".rdata"}, rsp_rdata, 32'h0);
  endtask

  // Counts edges after reset release until req_ready rises; bounded so a stuck busy fails.
  task automatic count_ready(input string tag, input int exp);
    int n;
    n = 0;
    while (n < DEPTH + 16) begin
      @(posedge clk);
      #1;
      n++;
      if (req_ready) break;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int exp_ready;
`ifdef DMEM_BYTE_CLEAR_EN
    exp_ready = DEPTH;
`else
    exp_ready = 1;
`endif
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    last_rd      = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(rsp_valid), 32'h0);
    chk("rst.mis", 32'(rsp_misalign), 32'h0);
    chk("rst.rdata", rsp_rdata, 32'h0);
    chk("rst.busy", 32'(busy), 32'(exp_ready != 1));
    rst = 1'b0;
    count_ready("ready_cycles", exp_ready);

`ifdef DMEM_BYTE_CLEAR_EN
    do_req(1'b0, 'h10, 2'd2, 1'b0, 32'h0, "clr_w10");
    chk("clr_w10.lit", last_rd, 32'h0);
`endif
    // Establish known contents in the model window for both builds.
    for (int a = 0; a < 256; a += 4) do_req(1'b1, a, 2'd2, 1'b0, 32'h0, "init");
    idle_chk("idle0");

    do_req(1'b1, 'h20, 2'd2, 1'b0, 32'h11223344, "st20");
    do_req(1'b0, 'h20, 2'd0, 1'b0, 32'h0, "lb20");
    chk("lb20.lit", last_rd, 32'h00000044);
    do_req(1'b0, 'h21, 2'd0, 1'b0, 32'h0, "lb21");
    chk("lb21.lit", last_rd, 32'h00000033);
    do_req(1'b0, 'h22, 2'd0, 1'b0, 32'h0, "lb22");
    chk("lb22.lit", last_rd, 32'h00000022);
    do_req(1'b0, 'h23, 2'd0, 1'b0, 32'h0, "lb23");
    chk("lb23.lit", last_rd, 32'h00000011);

    do_req(1'b1, 'h41, 2'd0, 1'b0, 32'h00000080, "sb41");
    do_req(1'b0, 'h40, 2'd2, 1'b0, 32'h0, "lw40");
    chk("lw40.lit", last_rd, 32'h00008000);
    do_req(1'b0, 'h41, 2'd0, 1'b0, 32'h0, "lb41s");
    chk("lb41s.lit", last_rd, 32'hFFFFFF80);
    do_req(1'b0, 'h41, 2'd0, 1'b1, 32'h0, "lb41u");
    chk("lb41u.lit", last_rd, 32'h00000080);

    do_req(1'b1, 'h44, 2'd2, 1'b0, 32'hCAFEF00D, "sw44");
    do_req(1'b0, 'h43, 2'd1, 1'b0, 32'h0, "lh43mis");
    do_req(1'b1, 'h46, 2'd2, 1'b0, 32'h12345678, "sw46mis");
    do_req(1'b0, 'h44, 2'd2, 1'b0, 32'h0, "lw44");
    chk("lw44.lit", last_rd, 32'hCAFEF00D);
    do_req(1'b0, 'h45, 2'd3, 1'b0, 32'h0, "lw45sz3mis");

    do_req(1'b1, 'h52, 2'd1, 1'b0, 32'h0000BEEF, "sh52");
    do_req(1'b0, 'h50, 2'd2, 1'b0, 32'h0, "lw50");
    chk("lw50.lit", last_rd, 32'hBEEF0000);
    do_req(1'b0, 'h52, 2'd1, 1'b0, 32'h0, "lh52s");
    chk("lh52s.lit", last_rd, 32'hFFFFBEEF);
    idle_chk("idle1");

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) idle_chk("rnd_idle");
      else do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, "rnd");
    end

    // Reset during an accepted-looking request must swallow its response.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'('h20);
    req_size  = 2'd2;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    chk("rstreq.valid", 32'(rsp_valid), 32'h0);
    chk("rstreq.rdata", rsp_rdata, 32'h0);
    req_valid = 1'b0;
    rst       = 1'b0;

`ifdef DMEM_BYTE_CLEAR_EN
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 50) chk("sweep.busy_mid", 32'(busy), 32'h1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("restart.busy", 32'(busy), 32'h1);
    rst = 1'b0;
    count_ready("restart_cycles", DEPTH);
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    do_req(1'b0, 'h20, 2'd2, 1'b0, 32'h0, "post_clr_w20");
    do_req(1'b0, 'h44, 2'd2, 1'b0, 32'h0, "post_clr_w44");
`else
    count_ready("off_ready", 1);
    chk("off.busy", 32'(busy), 32'h0);
    do_req(1'b1, 'h60, 2'd2, 1'b0, 32'hA5A55A5A, "off_sw60");
    do_req(1'b0, 'h62, 2'd1, 1'b1, 32'h0, "off_lh62u");
`endif
    idle_chk("idle_end");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
